// File: rtl/nqueens_pkg.sv
// nqueens_pkg: shared types and constants for the N-queens sequencing controller.
//   ctrl_state_t : controller FSM states
//   ROW_W        : row/column field width (board up to 8x8)
//   SIZE_W       : board-size width; one bit wider than a row so size-1 and col+1
//                  compare without wrap
//   N_MAX_DEF    : default largest supported board size
package nqueens_pkg;

    localparam int ROW_W     = 3;
    localparam int SIZE_W    = 4;
    localparam int N_MAX_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        PLACE,
        WRITE,
        BT_RD,
        BT_WAIT,
        FINISH
    } ctrl_state_t;

endpackage

// File: rtl/nqueens_ctrl.sv
// nqueens_ctrl: backtracking sequencer for the N-queens datapath.
//
// It walks rows and candidate columns and drives the checker's row/column
// inputs (n, i). Accepted columns are written to the 3-bit register file, and
// the block backtracks by reading stored columns back. It reports whether a
// first solution exists.
//
// Optional build macro NQ_COUNT_ALL_EN: when defined, the search visits the
// whole tree, counts solutions on sol_count, and ends only after it backtracks
// past row 0.
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   start, board_size      one-cycle search request and N (sampled on accept)
//   n, i, safe             row/column under test -> checker, combinational verdict
//   address_3, data_in_3,
//   load_3, read_3         register-file controls (zero when not strobing)
//   data_out_3             register-file read data, one cycle after read_3
//   busy, done             search in progress / one-cycle end pulse
//   solved, bad_size       result flags, held until next accepted start
//   cycles                 saturating busy-cycle count of the last search
//   sol_count              (NQ_COUNT_ALL_EN only) saturating solution count
module nqueens_ctrl
    import nqueens_pkg::*;
#(
    parameter int N_MAX = N_MAX_DEF,
    parameter int CYC_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [SIZE_W-1:0] board_size,
    output logic [ROW_W-1:0]  n,
    output logic [ROW_W-1:0]  i,
    input  logic              safe,
    output logic [ROW_W-1:0]  address_3,
    output logic [ROW_W-1:0]  data_in_3,
    output logic              load_3,
    output logic              read_3,
    input  logic [ROW_W-1:0]  data_out_3,
    output logic              busy,
    output logic              done,
    output logic              solved,
    output logic              bad_size,
`ifdef NQ_COUNT_ALL_EN
    output logic [7:0]        sol_count,
`endif
    output logic [CYC_W-1:0]  cycles
);

    localparam logic [SIZE_W-1:0] NMAX_S = SIZE_W'(N_MAX);

    ctrl_state_t       state;
    logic [SIZE_W-1:0] size_q;
    logic [ROW_W-1:0]  row_q;
    logic [ROW_W-1:0]  col_q;

    // Compares are done at SIZE_W so size-1 and col+1 never wrap.
    logic [SIZE_W-1:0] last;
    logic [SIZE_W-1:0] row_ext;
    logic [SIZE_W-1:0] col_ext;
    logic [SIZE_W-1:0] rd_next;
    logic [SIZE_W-1:0] wr_next;
    logic              size_ok;

    // Read request issued on the cycle we move into BT_RD. The strobe is
    // registered, so it must target row-1 now. It is suppressed at row 0,
    // where BT_RD simply ends the search.
    logic              bt_req;
    logic [ROW_W-1:0]  bt_addr;

    assign last    = size_q - 1'b1;
    assign row_ext = {1'b0, row_q};
    assign col_ext = {1'b0, col_q};
    assign rd_next = {1'b0, data_out_3} + 4'd1;
    assign wr_next = col_ext + 4'd1;
    assign size_ok = (board_size != '0) && (board_size <= NMAX_S);
    assign bt_req  = (row_q != '0);
    assign bt_addr = bt_req ? (row_q - 1'b1) : '0;

    assign n = row_q;
    assign i = col_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            size_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            address_3 <= '0;
            data_in_3 <= '0;
            load_3    <= 1'b0;
            read_3    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            solved    <= 1'b0;
            bad_size  <= 1'b0;
            cycles    <= '0;
`ifdef NQ_COUNT_ALL_EN
            sol_count <= '0;
`endif
        end else begin
            // Strobes and done are single-cycle unless a branch below re-arms them.
            load_3    <= 1'b0;
            read_3    <= 1'b0;
            address_3 <= '0;
            data_in_3 <= '0;
            done      <= 1'b0;

            if (busy && (cycles != '1))
                cycles <= cycles + 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        solved <= 1'b0;
                        cycles <= '0;
`ifdef NQ_COUNT_ALL_EN
                        sol_count <= '0;
`endif
                        if (size_ok) begin
                            size_q   <= board_size;
                            row_q    <= '0;
                            col_q    <= '0;
                            bad_size <= 1'b0;
                            busy     <= 1'b1;
                            state    <= PLACE;
                        end else begin
                            // Rejected size: report through FINISH so a start
                            // during the done pulse is ignored as usual.
                            bad_size <= 1'b1;
                            done     <= 1'b1;
                            state    <= FINISH;
                        end
                    end
                end

                PLACE: begin
                    if (safe) begin
                        load_3    <= 1'b1;
                        address_3 <= row_q;
                        data_in_3 <= col_q;
                        state     <= WRITE;
                    end else if (col_ext < last) begin
                        col_q <= col_q + 1'b1;
                    end else begin
                        read_3    <= bt_req;
                        address_3 <= bt_addr;
                        state     <= BT_RD;
                    end
                end

                WRITE: begin
                    if (row_ext < last) begin
                        row_q <= row_q + 1'b1;
                        col_q <= '0;
                        state <= PLACE;
                    end else begin
                        solved <= 1'b1;
`ifdef NQ_COUNT_ALL_EN
                        if (sol_count != 8'hFF)
                            sol_count <= sol_count + 1'b1;
                        // Resume as if the just-written column came back from
                        // the register file; no read is needed.
                        if (wr_next < size_q) begin
                            col_q <= col_q + 1'b1;
                            state <= PLACE;
                        end else begin
                            read_3    <= bt_req;
                            address_3 <= bt_addr;
                            state     <= BT_RD;
                        end
`else
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
`endif
                    end
                end

                BT_RD: begin
                    if (row_q == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        row_q <= row_q - 1'b1;
                        state <= BT_WAIT;
                    end
                end

                BT_WAIT: begin
                    if (rd_next < size_q) begin
                        col_q <= rd_next[ROW_W-1:0];
                        state <= PLACE;
                    end else begin
                        read_3    <= bt_req;
                        address_3 <= bt_addr;
                        state     <= BT_RD;
                    end
                end

                FINISH: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nqueens_ctrl.sv
// tb_nqueens_ctrl: self-checking bench for nqueens_ctrl. It supplies a
// behavioural register file and queen-safety checker, and compares results
// against a direct DFS solver kept in the bench.
module tb_nqueens_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] board_size;
    logic [2:0] n, i, address_3, data_in_3, data_out_3;
    logic       safe, load_3, read_3, busy, done, solved, bad_size;
    logic [15:0] cycles;
`ifdef NQ_COUNT_ALL_EN
    logic [7:0] sol_count;
    localparam int BUDGET = 400000;
`else
    localparam int BUDGET = 20000;
`endif

    always #5 clk = ~clk;

    nqueens_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .board_size(board_size),
        .n(n), .i(i), .safe(safe), .address_3(address_3), .data_in_3(data_in_3),
        .load_3(load_3), .read_3(read_3), .data_out_3(data_out_3),
        .busy(busy), .done(done), .solved(solved), .bad_size(bad_size),
`ifdef NQ_COUNT_ALL_EN
        .sol_count(sol_count),
`endif
        .cycles(cycles)
    );

    // Register file with one-cycle read latency.
    logic [2:0] rf [8];
    logic [2:0] rd_q = 3'd0;
    always @(posedge clk) begin
        if (load_3) rf[address_3] <= data_in_3;
        if (read_3) rd_q <= rf[address_3];
    end
    assign data_out_3 = rd_q;

    // Queen at (n, i) is safe if no earlier row shares its column or a diagonal.
    always_comb begin
        safe = 1'b1;
        for (int r = 0; r < 8; r++) begin
            if (r < int'(n)) begin
                if (rf[3'(r)] == i) safe = 1'b0;
                if ((int'(rf[3'(r)]) - int'(i) == int'(n) - r) ||
                    (int'(i) - int'(rf[3'(r)]) == int'(n) - r)) safe = 1'b0;
            end
        end
    end

    // Running strobe statistics; tests diff snapshots.
    int n_load = 0, n_read = 0, load_r2 = 0, viol = 0;
    always @(negedge clk) begin
        if (load_3) n_load++;
        if (read_3) n_read++;
        if (load_3 && address_3 == 3'd2) load_r2++;
        if (load_3 && read_3) viol++;
        if (!load_3 && !read_3 && (address_3 != 0 || data_in_3 != 0)) viol++;
    end

    int total = 0, passed = 0;
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference: plain DFS over column placements in lexicographic order.
    int m_cols[8];
    bit m_found;
    int m_count;
    task automatic model(input int sz);
        int c[8];
        int r;
        bit ok;
        m_found = 0; m_count = 0;
        for (int k = 0; k < 8; k++) begin m_cols[k] = 0; c[k] = 0; end
        if (sz < 1 || sz > 8) return;
        r = 0;
        while (r >= 0) begin
            if (c[r] >= sz) begin
                r--;
                if (r >= 0) c[r]++;
            end else begin
                ok = 1;
                for (int k = 0; k < r; k++)
                    if (c[k] == c[r] || c[k] - c[r] == r - k || c[r] - c[k] == r - k) ok = 0;
                if (!ok) c[r]++;
                else if (r == sz - 1) begin
                    m_count++;
                    if (!m_found) begin
                        m_found = 1;
                        for (int k = 0; k < 8; k++) m_cols[k] = c[k];
                    end
                    c[r]++;
                end else begin
                    r++;
                    c[r] = 0;
                end
            end
        end
    endtask

    int last_lat;
    bit last_to;
    task automatic run(input int sz);
        @(negedge clk);
        start = 1'b1; board_size = 4'(sz);
        last_lat = 0; last_to = 0;
        @(posedge clk); last_lat = 1;
        @(negedge clk); start = 1'b0;
        while (!done) begin
            if (last_lat >= BUDGET) begin last_to = 1; break; end
            @(posedge clk); last_lat++;
            @(negedge clk);
        end
    endtask

    // Full check of one search against the expected flags and the model.
    task automatic do_case(input int sz, input bit e_sol, input bit e_bad, input int e_cnt);
        int l0, r0, v0;
        logic [15:0] cyc;
        l0 = n_load; r0 = n_read; v0 = viol;
        run(sz);
        model(sz);
        chk($sformatf("timeout_n%0d", sz), int'(last_to), 0);
        chk($sformatf("solved_n%0d", sz), int'(solved), int'(e_sol));
        chk($sformatf("model_solved_n%0d", sz), int'(solved), int'(m_found));
        chk($sformatf("bad_size_n%0d", sz), int'(bad_size), int'(e_bad));
        chk($sformatf("busy_at_done_n%0d", sz), int'(busy), 0);
        if (e_bad) begin
            chk($sformatf("bad_latency_n%0d", sz), last_lat, 1);
            chk($sformatf("bad_strobes_n%0d", sz), (n_load - l0) + (n_read - r0), 0);
        end
`ifdef NQ_COUNT_ALL_EN
        chk($sformatf("sol_count_n%0d", sz), int'(sol_count), e_cnt);
        chk($sformatf("model_count_n%0d", sz), int'(sol_count), m_count);
`else
        if (m_found)
            for (int r = 0; r < sz; r++)
                chk($sformatf("rf_n%0d_row%0d", sz, r), int'(rf[3'(r)]), m_cols[r]);
        if (e_cnt < 0) chk("unreachable", 0, 1);
`endif
        chk($sformatf("strobe_rules_n%0d", sz), viol - v0, 0);
        cyc = cycles;
        if (!e_bad) chk($sformatf("cycles_nonzero_n%0d", sz), int'(cyc != 0), 1);
        @(posedge clk); @(negedge clk);
        chk($sformatf("done_pulse_n%0d", sz), int'(done), 0);
        chk($sformatf("cycles_stable_n%0d", sz), int'(cycles), int'(cyc));
    endtask

    typedef struct {
        int sz;
        bit e_sol;
        bit e_bad;
        int e_cnt;
    } vec_t;

    vec_t tbl[10];
    int l0;

    initial begin
        #20_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4, 1, 0, 2};   tbl[1] = '{8, 1, 0, 92};
        tbl[2] = '{3, 0, 0, 0};   tbl[3] = '{2, 0, 0, 0};
        tbl[4] = '{0, 0, 1, 0};   tbl[5] = '{9, 0, 1, 0};
        tbl[6] = '{15, 0, 1, 0};  tbl[7] = '{1, 1, 0, 1};
        tbl[8] = '{5, 1, 0, 10};  tbl[9] = '{6, 1, 0, 4};

        reset_n = 1'b0; start = 1'b0; board_size = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", int'({n, i, address_3, data_in_3, load_3, read_3,
                                  busy, done, solved, bad_size, cycles} != 0), 0);
`ifdef NQ_COUNT_ALL_EN
        chk("reset_sol_count", int'(sol_count), 0);
`endif
        reset_n = 1'b1;

        for (int k = 0; k < 10; k++) begin
            if (tbl[k].sz == 3) l0 = load_r2;
            do_case(tbl[k].sz, tbl[k].e_sol, tbl[k].e_bad, tbl[k].e_cnt);
            if (tbl[k].sz == 3) chk("n3_no_load_row2", load_r2 - l0, 0);
        end

`ifndef NQ_COUNT_ALL_EN
        // Known first solutions.
        run(4);
        chk("n4_rows", int'({rf[0], rf[1], rf[2], rf[3]}), int'({3'd1, 3'd3, 3'd0, 3'd2}));
        // A start raised during the done pulse must be ignored.
        start = 1'b1; board_size = 4'd1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        chk("start_on_done_ignored", int'(busy), 0);
        @(posedge clk); @(negedge clk);
        chk("still_idle", int'({busy, done}), 0);
        run(8);
        chk("n8_rows", int'({rf[0], rf[1], rf[2], rf[3], rf[4], rf[5], rf[6], rf[7]}),
            int'({3'd0, 3'd4, 3'd7, 3'd5, 3'd2, 3'd6, 3'd1, 3'd3}));
`endif
        // Size 1: PLACE, WRITE, then done; two busy cycles.
        run(1);
        chk("n1_latency", last_lat, 3);
        chk("n1_cycles", int'(cycles), 2);
        chk("n1_row0", int'(rf[0]), 0);

        // Reset mid-search, then a fresh search must still work.
        @(negedge clk); start = 1'b1; board_size = 4'd8;
        @(posedge clk); @(negedge clk); start = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk); reset_n = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("midsearch_reset_outputs", int'({n, i, address_3, data_in_3, load_3, read_3,
                                            busy, done, solved, bad_size, cycles} != 0), 0);
        reset_n = 1'b1;
        do_case(4, 1, 0, 2);

        // Random sizes against the model.
        for (int k = 0; k < 8; k++) begin
            int sz;
            bit ok;
            sz = int'($urandom_range(0, 15));
`ifdef NQ_COUNT_ALL_EN
            if (sz == 8) sz = 7;
`endif
            model(sz);
            ok = (sz >= 1 && sz <= 8);
            do_case(sz, m_found, !ok, m_count > 255 ? 255 : m_count);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
